// File: rtl/axioma_wdt_pkg.sv
// Shared constants and helpers for the watchdog controller: WDTCSR layout,
// mode encoding and the prescaler-to-timeout-limit mapping.
package axioma_wdt_pkg;

  localparam logic [7:0] WDTCSR_ADDR_DEFAULT = 8'h60;

  localparam int WDIF_BIT = 7;
  localparam int WDIE_BIT = 6;
  localparam int WDP3_BIT = 5;
  localparam int WDCE_BIT = 4;
  localparam int WDE_BIT  = 3;
  localparam int WDP2_BIT = 2;
  localparam int WDP0_BIT = 0;

  // Mode is {WDE, WDIE}
  localparam logic [1:0] MODE_STOP    = 2'b00;
  localparam logic [1:0] MODE_INT     = 2'b01;
  localparam logic [1:0] MODE_RST     = 2'b10;
  localparam logic [1:0] MODE_INT_RST = 2'b11;

  // Reserved prescaler codes 10..15 saturate at the longest period.
  function automatic logic [20:0] wdt_limit(input logic [3:0] wdp);
    logic [3:0] sel;
    sel = (wdp > 4'd9) ? 4'd9 : wdp;
    return 21'd2048 << sel;
  endfunction

endpackage

// File: rtl/axioma_wdt_ctrl_if.sv
// I/O-space register bus seen by the watchdog controller.
// Valid/ready note: there is no stall; io_write/io_read are single-cycle strobes
// qualified by io_addr, and io_data_out is valid in the same cycle as io_read.
interface axioma_wdt_ctrl_if;
  logic [7:0] io_addr;
  logic [7:0] io_data_in;
  logic [7:0] io_data_out;
  logic       io_write;
  logic       io_read;

  modport master (output io_addr, output io_data_in, output io_write, output io_read,
                  input io_data_out);
  modport slave  (input io_addr, input io_data_in, input io_write, input io_read,
                  output io_data_out);
endinterface

// File: rtl/axioma_wdt_timeout_counter.sv
// 21-bit watchdog tick counter; strobes o_timeout on the tick that completes
// the period selected by i_wdp and wraps back to zero.
module axioma_wdt_timeout_counter
  import axioma_wdt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_tick,
  input  logic        i_clear,
  input  logic        i_stop,
  input  logic [3:0]  i_wdp,
  output logic        o_timeout,
  output logic [20:0] o_count
);

  logic [20:0] r_count;
  logic [20:0] w_limit_m1;

  assign w_limit_m1 = wdt_limit(i_wdp) - 21'd1;
  // A clear (WDR or prescaler change) in the expiry cycle cancels the timeout.
  assign o_timeout  = i_enable && i_tick && !i_clear && (r_count == w_limit_m1);
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear || i_stop || !i_enable) begin
      r_count <= 21'd0;
    end else if (o_timeout) begin
      r_count <= 21'd0;
    end else if (i_tick) begin
      r_count <= r_count + 21'd1;
    end
  end

endmodule

// File: rtl/axioma_wdt_ctrl.sv
// WDTCSR register, WDCE timed-change window and mode handling around the
// watchdog timeout counter.
module axioma_wdt_ctrl
  import axioma_wdt_pkg::*;
#(
  parameter logic [7:0] WDTCSR_ADDR   = WDTCSR_ADDR_DEFAULT,
  parameter int         WINDOW_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wdt_tick,
  input  logic                   wdr,
  input  logic                   wdrf_in,
  input  logic                   irq_ack,
  axioma_wdt_ctrl_if.slave       bus,
  output logic                   wdt_enable,
  output logic [3:0]             wdt_prescaler,
  output logic                   wdt_reset_req,
  output logic                   wdt_irq,
  output logic                   wdt_sys_reset,
  output logic [20:0]            debug_wdt_count
);

  localparam int WIN_W = (WINDOW_CYCLES < 1) ? 1 : $clog2(WINDOW_CYCLES + 1);

  logic             r_wdif, r_wdie, r_wdce, r_wde;
  logic [3:0]       r_wdp;
  logic [WIN_W-1:0] r_win_cnt;
  logic             r_wdt_enable;
  logic [3:0]       r_wdt_prescaler;
  logic             r_reset_req, r_sys_reset;

  logic             w_wr_hit, w_win_open, w_win_load, w_win_commit;
  logic             w_wdif_n, w_wdie_sw, w_wdie_n, w_wde_n, w_wdce_n;
  logic [3:0]       w_wdp_n;
  logic [WIN_W-1:0] w_win_n;
  logic [1:0]       w_mode;
  logic             w_timeout, w_cnt_clear, w_cnt_stop;
  logic [20:0]      w_count;

  assign w_wr_hit     = bus.io_write && (bus.io_addr == WDTCSR_ADDR);
  assign w_win_open   = (r_win_cnt != '0);
  assign w_win_load   = w_wr_hit && bus.io_data_in[WDCE_BIT] && bus.io_data_in[WDE_BIT];
  assign w_win_commit = w_wr_hit && w_win_open && !bus.io_data_in[WDCE_BIT];
  assign w_mode       = {r_wde, r_wdie};

  // Software view of the next register contents (WDE, WDP, WDCE, window, WDIE).
  always_comb begin
    w_wde_n   = r_wde;
    w_wdp_n   = r_wdp;
    w_wdce_n  = r_wdce;
    w_win_n   = r_win_cnt;
    w_wdie_sw = r_wdie;
    if (w_win_open) begin
      w_win_n = r_win_cnt - WIN_W'(1);
      if (r_win_cnt == WIN_W'(1)) w_wdce_n = 1'b0;
    end
    if (w_wr_hit) begin
      w_wdie_sw = bus.io_data_in[WDIE_BIT];
      if (w_win_load) begin
        w_wdce_n = 1'b1;
        w_wde_n  = 1'b1;
        w_win_n  = WIN_W'(WINDOW_CYCLES);
      end else if (w_win_commit) begin
        w_wde_n  = bus.io_data_in[WDE_BIT];
        w_wdp_n  = {bus.io_data_in[WDP3_BIT], bus.io_data_in[WDP2_BIT:WDP0_BIT]};
        w_wdce_n = 1'b0;
        w_win_n  = '0;
      end else begin
        w_wde_n = r_wde | bus.io_data_in[WDE_BIT];
      end
    end
    if (wdrf_in) w_wde_n = 1'b1;
  end

  // Hardware flag updates take priority over software clears/writes.
  always_comb begin
    w_wdif_n = r_wdif;
    w_wdie_n = w_wdie_sw;
    if (irq_ack || (w_wr_hit && bus.io_data_in[WDIF_BIT])) w_wdif_n = 1'b0;
    if (w_timeout) begin
      case (w_mode)
        MODE_INT:     w_wdif_n = 1'b1;
        MODE_INT_RST: begin
          w_wdif_n = 1'b1;
          w_wdie_n = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign w_cnt_clear = wdr || (w_wdp_n != r_wdp);
  assign w_cnt_stop  = ({w_wde_n, w_wdie_sw} == MODE_STOP);

  axioma_wdt_timeout_counter u_counter (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (w_mode != MODE_STOP),
    .i_tick    (wdt_tick),
    .i_clear   (w_cnt_clear),
    .i_stop    (w_cnt_stop),
    .i_wdp     (r_wdp),
    .o_timeout (w_timeout),
    .o_count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdif          <= 1'b0;
      r_wdie          <= 1'b0;
      r_wdce          <= 1'b0;
      r_wde           <= wdrf_in;
      r_wdp           <= 4'd0;
      r_win_cnt       <= '0;
      r_wdt_enable    <= wdrf_in;
      r_wdt_prescaler <= 4'd0;
      r_reset_req     <= 1'b0;
      r_sys_reset     <= 1'b0;
    end else begin
      r_wdif          <= w_wdif_n;
      r_wdie          <= w_wdie_n;
      r_wdce          <= w_wdce_n;
      r_wde           <= w_wde_n;
      r_wdp           <= w_wdp_n;
      r_win_cnt       <= w_win_n;
      r_wdt_enable    <= w_wde_n | w_wdie_n;
      r_wdt_prescaler <= w_wdp_n;
      r_reset_req     <= wdr;
      r_sys_reset     <= w_timeout && (w_mode == MODE_RST);
    end
  end

  assign bus.io_data_out  = (bus.io_read && (bus.io_addr == WDTCSR_ADDR)) ?
                            {r_wdif, r_wdie, r_wdp[3], r_wdce, r_wde, r_wdp[2:0]} : 8'h00;
  assign wdt_enable       = r_wdt_enable;
  assign wdt_prescaler    = r_wdt_prescaler;
  assign wdt_reset_req    = r_reset_req;
  assign wdt_irq          = r_wdif & r_wdie;
  assign wdt_sys_reset    = r_sys_reset;
  assign debug_wdt_count  = w_count;

endmodule

// File: tb/tb_axioma_wdt_ctrl.sv
// Bench for axioma_wdt_ctrl: directed scenarios with fixed expectations, then
// random traffic checked cycle by cycle against a behavioural model.
module tb_axioma_wdt_ctrl;

  localparam int WIN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wdt_tick = 1'b0, wdr = 1'b0, wdrf_in = 1'b0, irq_ack = 1'b0;
  logic        wdt_enable, wdt_reset_req, wdt_irq, wdt_sys_reset;
  logic [3:0]  wdt_prescaler;
  logic [20:0] debug_wdt_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  axioma_wdt_ctrl_if bus ();

  axioma_wdt_ctrl #(.WDTCSR_ADDR(8'h60), .WINDOW_CYCLES(WIN)) dut (
    .clk(clk), .rst(rst), .wdt_tick(wdt_tick), .wdr(wdr), .wdrf_in(wdrf_in),
    .irq_ack(irq_ack), .bus(bus), .wdt_enable(wdt_enable), .wdt_prescaler(wdt_prescaler),
    .wdt_reset_req(wdt_reset_req), .wdt_irq(wdt_irq), .wdt_sys_reset(wdt_sys_reset),
    .debug_wdt_count(debug_wdt_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  logic       m_wdif, m_wdie, m_wde, m_wdce, m_sysrst, m_rreq;
  logic [3:0] m_wdp;
  int         m_win, m_cnt;

  function automatic logic [7:0] m_reg();
    return {m_wdif, m_wdie, m_wdp[3], m_wdce, m_wde, m_wdp[2:0]};
  endfunction

  function automatic void model_step();
    logic [7:0] d;
    logic       hit, tmo, wdif_n, wdie_n, wde_n, wdce_n;
    logic [3:0] wdp_n;
    int         win_n, lim;
    if (rst) begin
      m_wdif = 0; m_wdie = 0; m_wdce = 0; m_wdp = 0; m_wde = wdrf_in;
      m_win = 0; m_cnt = 0; m_sysrst = 0; m_rreq = 0;
      return;
    end
    d   = bus.io_data_in;
    hit = bus.io_write && (bus.io_addr == 8'h60);
    wdif_n = m_wdif; wdie_n = m_wdie; wde_n = m_wde; wdce_n = m_wdce;
    wdp_n = m_wdp; win_n = m_win;
    if (m_win > 0) begin
      win_n = m_win - 1;
      if (m_win == 1) wdce_n = 0;
    end
    if (hit) begin
      wdie_n = d[6];
      if (d[7]) wdif_n = 0;
      if (d[4] && d[3]) begin
        wdce_n = 1; wde_n = 1; win_n = WIN;
      end else if (m_win > 0 && !d[4]) begin
        wde_n = d[3]; wdp_n = {d[5], d[2:0]}; wdce_n = 0; win_n = 0;
      end else if (d[3]) begin
        wde_n = 1;
      end
    end
    if (irq_ack) wdif_n = 0;
    if (wdrf_in) wde_n = 1;
    lim = 2048 << ((m_wdp > 9) ? 9 : m_wdp);
    tmo = (m_wde || m_wdie) && wdt_tick && !wdr && (wdp_n == m_wdp) && (m_cnt == lim - 1);
    m_sysrst = tmo && m_wde && !m_wdie;
    if (tmo && m_wdie) begin
      wdif_n = 1;
      if (m_wde) wdie_n = 0;
    end
    if (!(m_wde || m_wdie) || !(wde_n || wdie_n) || wdr || (wdp_n != m_wdp)) m_cnt = 0;
    else if (wdt_tick) m_cnt = tmo ? 0 : m_cnt + 1;
    m_rreq = wdr;
    m_wdif = wdif_n; m_wdie = wdie_n; m_wde = wde_n; m_wdce = wdce_n;
    m_wdp = wdp_n; m_win = win_n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    bus.io_write = 1'b0; wdr = 1'b0; wdt_tick = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      wdt_tick = 1'b1;
      step();
    end
  endtask

  task automatic wr(input logic [7:0] d);
    bus.io_addr = 8'h60; bus.io_data_in = d; bus.io_write = 1'b1;
    step();
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1; wdrf_in = v;
    step(); step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic v;
    for (int k = 0; k < 2; k++) begin
      v = (k == 1);
      do_reset(v);
      n_checks++; if (bus.io_data_out !== (v ? 8'h08 : 8'h00)) begin n_fail++; $display("FAIL rst_reg(wdrf=%0d): got %h exp %h", v, bus.io_data_out, (v ? 8'h08 : 8'h00)); end
      n_checks++; if (wdt_enable !== v) begin n_fail++; $display("FAIL rst_enable(wdrf=%0d): got %b exp %b", v, wdt_enable, v); end
      n_checks++; if ({wdt_prescaler, wdt_reset_req, wdt_irq, wdt_sys_reset} !== 7'd0) begin n_fail++; $display("FAIL rst_outputs: got %b exp 0", {wdt_prescaler, wdt_reset_req, wdt_irq, wdt_sys_reset}); end
      n_checks++; if (debug_wdt_count !== 21'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", debug_wdt_count); end
    end
    // With WDRF still set, a timed change cannot clear WDE.
    wr(8'h18); wr(8'h00);
    n_checks++; if (bus.io_data_out !== 8'h08) begin n_fail++; $display("FAIL wdrf_holds_wde: got %h exp 08", bus.io_data_out); end
    wdrf_in = 1'b0;
  endtask

  task automatic test_timed_change();
    do_reset(1'b0);
    wr(8'h18);
    n_checks++; if (bus.io_data_out !== 8'h18) begin n_fail++; $display("FAIL win_open_reg: got %h exp 18", bus.io_data_out); end
    idle(1); wr(8'h0E);
    n_checks++; if (bus.io_data_out !== 8'h0E) begin n_fail++; $display("FAIL commit_k2_reg: got %h exp 0E", bus.io_data_out); end
    n_checks++; if (wdt_prescaler !== 4'd6) begin n_fail++; $display("FAIL commit_k2_wdp: got %0d exp 6", wdt_prescaler); end
    do_reset(1'b0);
    wr(8'h18); idle(3); wr(8'h0D);
    n_checks++; if (bus.io_data_out !== 8'h0D) begin n_fail++; $display("FAIL commit_k4_reg: got %h exp 0D", bus.io_data_out); end
    do_reset(1'b0);
    wr(8'h18); idle(4);
    n_checks++; if (bus.io_data_out !== 8'h08) begin n_fail++; $display("FAIL wdce_expire: got %h exp 08", bus.io_data_out); end
    wr(8'h0E);
    n_checks++; if (bus.io_data_out !== 8'h08) begin n_fail++; $display("FAIL late_k5_reg: got %h exp 08", bus.io_data_out); end
    n_checks++; if (wdt_prescaler !== 4'd0) begin n_fail++; $display("FAIL late_k5_wdp: got %0d exp 0", wdt_prescaler); end
    do_reset(1'b0);
    wr(8'h18); idle(3); wr(8'h18); idle(3); wr(8'h0E);
    n_checks++; if (bus.io_data_out !== 8'h0E) begin n_fail++; $display("FAIL win_reload: got %h exp 0E", bus.io_data_out); end
    do_reset(1'b0);
    wr(8'h18); wr(8'h00);
    n_checks++; if ({bus.io_data_out, wdt_enable} !== 9'h000) begin n_fail++; $display("FAIL commit_clear_wde: got %h/%b exp 00/0", bus.io_data_out, wdt_enable); end
  endtask

  task automatic test_irq_mode();
    do_reset(1'b0);
    wr(8'h40);
    n_checks++; if ({bus.io_data_out, wdt_enable} !== {8'h40, 1'b1}) begin n_fail++; $display("FAIL irq_setup: got %h/%b exp 40/1", bus.io_data_out, wdt_enable); end
    ticks(2047);
    n_checks++; if (debug_wdt_count !== 21'd2047) begin n_fail++; $display("FAIL irq_count_2047: got %0d exp 2047", debug_wdt_count); end
    n_checks++; if (wdt_irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b exp 0", wdt_irq); end
    ticks(1);
    n_checks++; if (bus.io_data_out !== 8'hC0) begin n_fail++; $display("FAIL irq_wdif_set: got %h exp C0", bus.io_data_out); end
    n_checks++; if (wdt_irq !== 1'b1) begin n_fail++; $display("FAIL irq_out: got %b exp 1", wdt_irq); end
    n_checks++; if (debug_wdt_count !== 21'd0) begin n_fail++; $display("FAIL irq_wrap: got %0d exp 0", debug_wdt_count); end
    irq_ack = 1'b1; step();
    n_checks++; if ({bus.io_data_out, wdt_irq} !== {8'h40, 1'b0}) begin n_fail++; $display("FAIL irq_ack_clear: got %h/%b exp 40/0", bus.io_data_out, wdt_irq); end
  endtask

  task automatic test_int_then_reset();
    do_reset(1'b0);
    wr(8'h48);
    ticks(2048);
    n_checks++; if (bus.io_data_out !== 8'h88) begin n_fail++; $display("FAIL ir_first_timeout: got %h exp 88", bus.io_data_out); end
    n_checks++; if ({wdt_irq, wdt_sys_reset} !== 2'b00) begin n_fail++; $display("FAIL ir_first_outs: got %b exp 00", {wdt_irq, wdt_sys_reset}); end
    ticks(2047);
    n_checks++; if (wdt_sys_reset !== 1'b0) begin n_fail++; $display("FAIL ir_early_reset: got %b exp 0", wdt_sys_reset); end
    ticks(1);
    n_checks++; if (wdt_sys_reset !== 1'b1) begin n_fail++; $display("FAIL ir_second_reset: got %b exp 1", wdt_sys_reset); end
    step();
    n_checks++; if (wdt_sys_reset !== 1'b0) begin n_fail++; $display("FAIL ir_reset_width: got %b exp 0", wdt_sys_reset); end
  endtask

  task automatic test_wdr_race();
    do_reset(1'b0);
    wr(8'h08);
    ticks(2047);
    wdr = 1'b1; wdt_tick = 1'b1; step();
    n_checks++; if (wdt_sys_reset !== 1'b0) begin n_fail++; $display("FAIL wdr_race_reset: got %b exp 0", wdt_sys_reset); end
    n_checks++; if (debug_wdt_count !== 21'd0) begin n_fail++; $display("FAIL wdr_race_count: got %0d exp 0", debug_wdt_count); end
    n_checks++; if (wdt_reset_req !== 1'b1) begin n_fail++; $display("FAIL wdr_req_pulse: got %b exp 1", wdt_reset_req); end
    step();
    n_checks++; if ({wdt_reset_req, wdt_sys_reset} !== 2'b00) begin n_fail++; $display("FAIL wdr_req_width: got %b exp 00", {wdt_reset_req, wdt_sys_reset}); end
  endtask

  task automatic test_wde_sticky();
    wr(8'h00);
    n_checks++; if (bus.io_data_out !== 8'h08) begin n_fail++; $display("FAIL wde_sticky: got %h exp 08", bus.io_data_out); end
    wr(8'h47);
    n_checks++; if (bus.io_data_out !== 8'h48) begin n_fail++; $display("FAIL wdie_free_wdp_locked: got %h exp 48", bus.io_data_out); end
  endtask

  task automatic test_rst_mid_window();
    do_reset(1'b0);
    wr(8'h18);
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++; if (bus.io_data_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_window: got %h exp 00", bus.io_data_out); end
    wr(8'h0E);
    n_checks++; if ({bus.io_data_out, wdt_prescaler} !== {8'h08, 4'd0}) begin n_fail++; $display("FAIL window_closed_by_rst: got %h/%0d exp 08/0", bus.io_data_out, wdt_prescaler); end
  endtask

  task automatic test_wdp_change();
    do_reset(1'b0);
    wr(8'h08); ticks(100);
    n_checks++; if (debug_wdt_count !== 21'd100) begin n_fail++; $display("FAIL wdp_pre_count: got %0d exp 100", debug_wdt_count); end
    wr(8'h18); wr(8'h09);
    n_checks++; if ({debug_wdt_count, wdt_prescaler} !== {21'd0, 4'd1}) begin n_fail++; $display("FAIL wdp_change_clear: got %0d/%0d exp 0/1", debug_wdt_count, wdt_prescaler); end
    ticks(2048);
    n_checks++; if ({debug_wdt_count, wdt_sys_reset} !== {21'd2048, 1'b0}) begin n_fail++; $display("FAIL wdp1_no_early: got %0d/%b exp 2048/0", debug_wdt_count, wdt_sys_reset); end
    ticks(2048);
    n_checks++; if (wdt_sys_reset !== 1'b1) begin n_fail++; $display("FAIL wdp1_timeout_4096: got %b exp 1", wdt_sys_reset); end
  endtask

  task automatic test_addr_decode();
    do_reset(1'b0);
    bus.io_addr = 8'h61; bus.io_data_in = 8'h40; bus.io_write = 1'b1; step();
    bus.io_addr = 8'h60; #1;
    n_checks++; if (bus.io_data_out !== 8'h00) begin n_fail++; $display("FAIL addr_wrong_write: got %h exp 00", bus.io_data_out); end
    wr(8'h40);
    bus.io_addr = 8'h61; #1;
    n_checks++; if (bus.io_data_out !== 8'h00) begin n_fail++; $display("FAIL addr_wrong_read: got %h exp 00", bus.io_data_out); end
    bus.io_addr = 8'h60; bus.io_read = 1'b0; #1;
    n_checks++; if (bus.io_data_out !== 8'h00) begin n_fail++; $display("FAIL read_low: got %h exp 00", bus.io_data_out); end
    bus.io_read = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] exp_d;
    do_reset(1'b0);
    for (int c = 0; c < 20000; c++) begin
      rst         = ($urandom_range(0, 7999) == 0);
      wdrf_in     = ($urandom_range(0, 31) == 0);
      wdt_tick    = ($urandom_range(0, 1) == 1);
      wdr         = ($urandom_range(0, 4095) == 0);
      irq_ack     = ($urandom_range(0, 15) == 0);
      bus.io_read = ($urandom_range(0, 7) != 0);
      bus.io_addr = ($urandom_range(0, 15) == 0) ? 8'h61 : 8'h60;
      if ($urandom_range(0, 7) == 0) begin
        bus.io_write = 1'b1;
        case ($urandom_range(0, 2))
          0:       bus.io_data_in = 8'h18 | (8'($urandom) & 8'hC0);
          1:       bus.io_data_in = 8'($urandom) & 8'hC8;
          default: bus.io_data_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & 8'hE8);
        endcase
      end
      step();
      exp_q.push_back((bus.io_read && bus.io_addr == 8'h60) ? m_reg() : 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (bus.io_data_out !== exp_d) begin n_fail++; $display("FAIL rnd_reg c=%0d: got %h exp %h", c, bus.io_data_out, exp_d); end
      n_checks++; if (wdt_enable !== (m_wde | m_wdie)) begin n_fail++; $display("FAIL rnd_enable c=%0d: got %b exp %b", c, wdt_enable, m_wde | m_wdie); end
      n_checks++; if (wdt_prescaler !== m_wdp) begin n_fail++; $display("FAIL rnd_wdp c=%0d: got %0d exp %0d", c, wdt_prescaler, m_wdp); end
      n_checks++; if (wdt_reset_req !== m_rreq) begin n_fail++; $display("FAIL rnd_reset_req c=%0d: got %b exp %b", c, wdt_reset_req, m_rreq); end
      n_checks++; if (wdt_irq !== (m_wdif & m_wdie)) begin n_fail++; $display("FAIL rnd_irq c=%0d: got %b exp %b", c, wdt_irq, m_wdif & m_wdie); end
      n_checks++; if (wdt_sys_reset !== m_sysrst) begin n_fail++; $display("FAIL rnd_sys_reset c=%0d: got %b exp %b", c, wdt_sys_reset, m_sysrst); end
      n_checks++; if (debug_wdt_count !== 21'(m_cnt)) begin n_fail++; $display("FAIL rnd_count c=%0d: got %0d exp %0d", c, debug_wdt_count, m_cnt); end
    end
    rst = 1'b0; wdrf_in = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.io_addr = 8'h60; bus.io_data_in = 8'h00; bus.io_write = 1'b0; bus.io_read = 1'b1;
    test_reset();
    test_timed_change();
    test_irq_mode();
    test_int_then_reset();
    test_wdr_race();
    test_wde_sticky();
    test_rst_mid_window();
    test_wdp_change();
    test_addr_decode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axioma_wdt_ctrl.md
# axioma_wdt_ctrl

Watchdog control block implementing the ATmega328P WDTCSR register, the WDCE timed-change sequence and the watchdog timeout counter with interrupt / reset / interrupt-then-reset modes. It sits directly upstream of the clock and reset system. It feeds that system `wdt_enable`, `wdt_prescaler` and `wdt_reset_req`, and issues the watchdog system-reset request. It is clocked by the CPU clock and counts on a 128 kHz tick strobe.

## Interface
- `WDTCSR_ADDR`, default `8'h60`: data-space address of WDTCSR.
- `WINDOW_CYCLES`, default `4`: length of the WDCE timed-change window, in `clk` cycles.
- `clk`  in  1  CPU clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `wdt_tick`  in  1  one-cycle strobe at the 128 kHz watchdog oscillator rate.
- `wdr`  in  1  WDR instruction executed (one-cycle pulse).
- `wdrf_in`  in  1  MCUSR.WDRF; while 1, forces WDE = 1.
- `irq_ack`  in  1  interrupt vector taken; clears WDIF.
- `io_addr`  in  8  register address.
- `io_data_in`  in  8  write data.
- `io_write`  in  1  write strobe.
- `io_read`  in  1  read strobe.
- `io_data_out`  out  8  read data; combinational; 0 unless `io_read` is high and the address matches.
- `wdt_enable`  out  1  WDE | WDIE, registered.
- `wdt_prescaler`  out  4  WDP[3:0], registered.
- `wdt_reset_req`  out  1  one-cycle pulse, the cycle after `wdr`.
- `wdt_irq`  out  1  WDIF & WDIE.
- `wdt_sys_reset`  out  1  one-cycle reset-request pulse.
- `debug_wdt_count`  out  21  current timeout counter value.

## Operation
- WDTCSR bit map: [7] WDIF, [6] WDIE, [5] WDP3, [4] WDCE, [3] WDE, [2:0] WDP2..0.
- Reset values:
  - WDIF, WDIE, WDCE, WDP = 0.
  - WDE = `wdrf_in`.
  - Window counter and timeout counter = 0.
  - All outputs 0, except `wdt_enable` = `wdrf_in`.
- Writes to WDIE are applied on every write, unconditionally.
- Writing 1 to WDIF clears it. Writing 0 to WDIF has no effect.
- Opening the window: a write with WDCE = 1 and WDE = 1 sets WDCE and loads the window counter with `WINDOW_CYCLES`. WDP is unchanged by that write.
- Inside the window (window counter ≠ 0), a write with WDCE = 0:
  - loads WDE and WDP;
  - WDE cannot go to 0 while `wdrf_in` = 1;
  - clears WDCE and closes the window.
- The window counter decrements each cycle. When it reaches 0, WDCE clears.
- Outside the window:
  - WDE can be set but not cleared;
  - WDP writes are ignored.
- Timeout limit:
  - limit = 2048 << WDP ticks for WDP 0..9;
  - WDP 10..15 (reserved) behave as WDP = 9 (1,048,576 ticks).
- Mode is {WDE, WDIE}:
  - 00: stopped. Counter held at 0.
  - 01: interrupt. On timeout, set WDIF.
  - 10: reset. On timeout, pulse `wdt_sys_reset`.
  - 11: interrupt-then-reset. On timeout, set WDIF and clear WDIE in hardware, so mode becomes 10 and the next timeout resets.
- Counter:
  - increments on `wdt_tick` while enabled;
  - timeout occurs when count = limit−1 and `wdt_tick` is high; count then returns to 0;
  - clears on `wdr`, on any WDP change, and on transition to mode 00.

## Timing
- Register write is visible on `io_data_out` the cycle after `io_write`.
- Timeout cycle N: WDIF / WDIE / `wdt_sys_reset` update at edge N+1, so `wdt_irq` and `wdt_sys_reset` are high during cycle N+1.
- `wdt_reset_req` is high for exactly one cycle, the cycle after `wdr`.
- Window length: a write issued 1..`WINDOW_CYCLES` cycles after the enabling write succeeds. A write at `WINDOW_CYCLES`+1 is ignored.
- Simultaneous events:
  - `wdr` and timeout in the same cycle: `wdr` wins; no timeout, count = 0.
  - Hardware WDIF set together with a software WDIF-clear or `irq_ack`: the set wins.
  - Hardware WDIE clear (mode 11) together with a software WDIE write: the hardware clear wins.
  - Window-enable write arriving while the window is already open: the window reloads.
- `rst` mid-window or mid-count: all state returns to reset values at the next edge. A pending pulse is dropped.

## Structure
- Package `axioma_wdt_pkg` holds:
  - address default;
  - WDTCSR bit-index constants;
  - mode encoding constants (STOP, INT, RST, INT_RST);
  - `wdt_limit(wdp)` function returning 21 bits.
- Sub-module `axioma_wdt_timeout_counter` contains the 21-bit counter, limit compare and clear/tick logic, and outputs a timeout strobe. The top level holds the register, window and mode logic.

## Test plan
- After reset with `wdrf_in` = 0, read 0x60 → 0x00; all outputs 0. Repeat with `wdrf_in` = 1 → read 0x08, `wdt_enable` = 1.
- Write 0x18, then 0x0E two cycles later → WDTCSR = 0x0E, `wdt_prescaler` = 6. Write 0x18, then 0x0E five cycles later → WDTCSR = 0x08, WDP unchanged.
- Write 0x40 (WDIE, WDP = 0), then send 2048 ticks → WDIF = 1 and `wdt_irq` = 1 the cycle after tick 2048. `irq_ack` → WDIF = 0.
- Mode 11 with WDP = 0 → first timeout: WDIF = 1, WDIE = 0. After 2048 more ticks → single-cycle `wdt_sys_reset`.
- Mode 10; `wdr` on the same cycle as tick 2048 → no reset, `debug_wdt_count` = 0, `wdt_reset_req` pulses once.
- Outside the window, write 0x00 with WDE = 1 → WDE stays 1. Assert `rst` mid-window → window closed and WDCE = 0 next cycle.
